lcd_nibble_tx: RTL

Byte-to-nibble write sequencer for the 4-bit HD44780-style character LCD interface on the SF_D[11:8] shared bus. It sits directly downstream of the LCD initialization/display controller. The controller presents a 10-bit command word and holds an enable. This block drives LCD_E, LCD_RS, LCD_RW and SF_D8..SF_D11 through upper-nibble and lower-nibble strobes with 50 MHz-derived timing, then pulses `done`.

---
 rtl/lcd_nibble_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lcd_nibble_tx.sv
// Byte-to-nibble write sequencer for the 4-bit HD44780 LCD bus (SF_D[11:8]).
// Optional macro LCD_TX_LONG_CMD_EN: clear/home commands wait T_LONG instead of T_WAIT.
module lcd_nibble_tx #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 50,
  parameter int unsigned T_WAIT  = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       en,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       SF_D8,
  output logic       SF_D9,
  output logic       SF_D10,
  output logic       SF_D11,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP_H, S_E_H, S_HOLD_H, S_GAP,
    S_SETUP_L, S_E_L, S_HOLD_L, S_WAIT, S_DONE
  } state_t;

  localparam logic [16:0] SETUP_M1 = 17'(T_SETUP - 1);
  localparam logic [16:0] E_M1     = 17'(T_E - 1);
  localparam logic [16:0] HOLD_M1  = 17'(T_HOLD - 1);
  localparam logic [16:0] GAP_M1   = 17'(T_GAP - 1);
  localparam logic [16:0] WAIT_M1  = 17'(T_WAIT - 1);
  localparam logic [16:0] LONG_M1  = 17'(T_LONG - 1);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [9:0]  word_q, word_d;
  logic        long_cmd;
  logic [16:0] wait_m1;

  logic        e_q, rs_q, rw_q, done_q;
  logic [3:0]  nib_q;
  logic        e_d, rs_d, rw_d, done_d;
  logic [3:0]  nib_d;
  logic        upper, lower;

  always_comb begin
`ifdef LCD_TX_LONG_CMD_EN
    long_cmd = (word_q[9:8] == 2'b00) &&
               ((word_q[7:0] == 8'h01) || (word_q[7:0] == 8'h02) || (word_q[7:0] == 8'h03));
`else
    long_cmd = 1'b0;
`endif
    wait_m1 = long_cmd ? LONG_M1 : WAIT_M1;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q + 17'd1;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          word_d  = data;
          state_d = S_SETUP_H;
        end
      end
      S_SETUP_H: if (cnt_q == SETUP_M1) state_d = S_E_H;
      S_E_H:     if (cnt_q == E_M1)     state_d = S_HOLD_H;
      S_HOLD_H:  if (cnt_q == HOLD_M1)  state_d = S_GAP;
      S_GAP:     if (cnt_q == GAP_M1)   state_d = S_SETUP_L;
      S_SETUP_L: if (cnt_q == SETUP_M1) state_d = S_E_L;
      S_E_L:     if (cnt_q == E_M1)     state_d = S_HOLD_L;
      S_HOLD_L:  if (cnt_q == HOLD_M1)  state_d = S_WAIT;
      S_WAIT:    if (cnt_q == wait_m1)  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    upper  = (state_d == S_SETUP_H) || (state_d == S_E_H) || (state_d == S_HOLD_H);
    lower  = (state_d == S_SETUP_L) || (state_d == S_E_L) || (state_d == S_HOLD_L);
    e_d    = (state_d == S_E_H) || (state_d == S_E_L);
    rs_d   = (upper || lower) && word_d[9];
    rw_d   = (upper || lower) && word_d[8];
    nib_d  = upper ? word_d[7:4] : (lower ? word_d[3:0] : 4'h0);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      nib_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      nib_q   <= nib_d;
      done_q  <= done_d;
    end
  end

  assign LCD_E  = e_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = rw_q;
  assign {SF_D11, SF_D10, SF_D9, SF_D8} = nib_q;
  assign done   = done_q;

endmodule
